// File: rtl/packet_scheduler_if.sv
// packet_scheduler_if: analyser-side push bus, sender-side packet bus and status
interface packet_scheduler_if #(parameter int ADDR_W = 4);
  logic              in_valid;
  logic [39:0]       in_data;
  logic              in_ready;
  logic              all_bytes_sent;
  logic [39:0]       out_data;
  logic              out_is_event;
  logic [ADDR_W:0]   fifo_level;
  logic [15:0]       drop_count;
  modport master (output in_valid, in_data, all_bytes_sent, input in_ready, out_data, out_is_event, fifo_level, drop_count);
  modport slave (input in_valid, in_data, all_bytes_sent, output in_ready, out_data, out_is_event, fifo_level, drop_count);
endinterface

// File: rtl/packet_scheduler.sv
// packet_scheduler: event FIFO feeding the SPI sender one word per packet; PACKET_SCHEDULER_OVERFLOW_MARKER_EN adds overflow marker words
module packet_scheduler #(
  parameter int          ADDR_W    = 4,
  parameter logic [39:0] IDLE_WORD = 40'h00_0000_0000
) (
  input logic clk,
  input logic rst,
  packet_scheduler_if.slave bus
);
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(2**ADDR_W);
  typedef enum logic [1:0] {
    IDLE,
    EVENT
`ifdef PACKET_SCHEDULER_OVERFLOW_MARKER_EN
    , MARKER
`endif
  } state_t;
  state_t state, state_nxt;
  logic [39:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0] level;
  logic [15:0] drops;
  logic [39:0] data_q;
  logic push, pop, drop;
  assign bus.in_ready = level != DEPTH;
  assign push = bus.in_valid & bus.in_ready;
  assign drop = bus.in_valid & ~bus.in_ready;
  assign bus.fifo_level = level;
  assign bus.drop_count = drops;
`ifdef PACKET_SCHEDULER_OVERFLOW_MARKER_EN
  logic mark_pend, mark_go;
  logic [7:0] mark_cnt, mark_q;
  assign mark_go = bus.all_bytes_sent & mark_pend;
  assign pop = bus.all_bytes_sent & ~mark_pend & (level != '0);
  // track drops since the last marker; a drop on the load edge restarts the count at 1
  always_ff @(posedge clk)
    if (rst) begin
      mark_pend <= 1'b0;
      mark_cnt <= '0;
      mark_q <= '0;
    end else begin
      if (mark_go) mark_q <= mark_cnt;
      if (drop) begin
        mark_pend <= 1'b1;
        mark_cnt <= mark_go ? 8'd1 : mark_cnt == 8'hFF ? mark_cnt : mark_cnt + 8'd1;
      end else if (mark_go) begin
        mark_pend <= 1'b0;
        mark_cnt <= '0;
      end
    end
`else
  assign pop = bus.all_bytes_sent & (level != '0);
`endif
  // storage array, written on every accepted push
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= bus.in_data;
  // pointers, level, drop counter and the word loaded for the current packet
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      drops <= '0;
      data_q <= IDLE_WORD;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        data_q <= mem[rd_ptr];
      end
      level <= level + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
      if (drop && drops != 16'hFFFF) drops <= drops + 16'd1;
    end
  // state register
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  // state changes only at packet boundaries
  always_comb begin
`ifdef PACKET_SCHEDULER_OVERFLOW_MARKER_EN
    state_nxt = !bus.all_bytes_sent ? state : mark_pend ? MARKER : level != '0 ? EVENT : IDLE;
`else
    state_nxt = !bus.all_bytes_sent ? state : level != '0 ? EVENT : IDLE;
`endif
  end
  // presented word and event flag decoded from the state
  always_comb begin
    bus.out_is_event = state == EVENT;
`ifdef PACKET_SCHEDULER_OVERFLOW_MARKER_EN
    bus.out_data = state == EVENT ? data_q : state == MARKER ? {32'hFFFF_FFFF, mark_q} : IDLE_WORD;
`else
    bus.out_data = state == EVENT ? data_q : IDLE_WORD;
`endif
  end
endmodule

// File: doc/packet_scheduler.md
# packet_scheduler

Buffers timestamped pin-change events from the signal analyser in a FIFO and presents them one packet at a time to the SPI data sender. The block sits between the analyser output (40-bit `{time[31:0], pins[7:0]}` words) and the sender's `dataIn`. It guarantees the presented word never changes mid-packet, substitutes an idle word when no events are pending, and accounts for events dropped on overflow.

## Interface
Parameters:
- `ADDR_W`, 4: FIFO address width; depth `DEPTH = 2**ADDR_W` entries of 40 bits.
- `IDLE_WORD`, 40'h00_0000_0000: word presented when no event is loaded.

Ports:
- `clk` in 1: sole clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: analyser has an event on `in_data`.
- `in_data` in 40: event word `{time[31:0], pins[7:0]}`.
- `in_ready` out 1: FIFO can accept; push occurs when `in_valid && in_ready`.
- `all_bytes_sent` in 1: one-cycle pulse from the sender marking a packet boundary.
- `out_data` out 40: word for the sender's `dataIn`; changes only on the edge where `all_bytes_sent` is sampled high.
- `out_is_event` out 1: high while `out_data` holds a FIFO event, not the idle or marker word.
- `fifo_level` out ADDR_W+1: entries currently stored, 0..DEPTH.
- `drop_count` out 16: events dropped since reset, saturating at 16'hFFFF.

## Operation
- States: `IDLE` (`out_data = IDLE_WORD`, `out_is_event = 0`), `EVENT` (`out_data = popped entry`, `out_is_event = 1`), `MARKER` (macro only).
- FIFO: circular buffer with read/write pointers of ADDR_W bits that wrap modulo DEPTH. `fifo_level` is an explicit counter.
- `in_ready = (fifo_level != DEPTH)`. It is combinational from the registered level and does not anticipate a same-cycle pop.
- Overflow: `in_valid && !in_ready` drops the event and increments `drop_count` (saturating). The FIFO contents are untouched.
- Boundary edge (`all_bytes_sent == 1`):
  - Marker pending (macro only): go to `MARKER`.
  - Else if `fifo_level > 0`: pop the head into `out_data` and go to `EVENT`.
  - Else: `out_data <= IDLE_WORD` and go to `IDLE`.
- Outside boundary edges, `out_data`, `out_is_event` and the state hold.
- Push and pop on the same edge: both take effect and `fifo_level` is unchanged. An entry pushed on edge N can be popped no earlier than a boundary on edge N+1.
- A popped entry is consumed on load. It is not re-sent if the next boundary arrives.
- Reset values: pointers 0, `fifo_level` 0, `drop_count` 0, `out_data = IDLE_WORD`, `out_is_event` 0, state `IDLE`, `in_ready` 1. This holds also when reset is asserted mid-packet or mid-push; the stored contents are discarded.
- `all_bytes_sent` during reset is ignored.

## Timing
- Push latency: FIFO write and level update on the edge where `in_valid && in_ready` is sampled.
- Load latency: `out_data` is valid in the cycle after the boundary edge. The sender samples it at the start of its next packet.
- Minimum spacing between two boundaries is one cycle. Back-to-back pulses pop on consecutive edges.
- `in_ready` deasserts in the cycle after the push that fills the FIFO. It reasserts in the cycle after a pop from full.

## Configuration
- `PACKET_SCHEDULER_OVERFLOW_MARKER_EN` defined:
  - A 1-bit `marker_pending` is set on any drop.
  - At the next boundary it takes priority over the FIFO. `out_data <= {32'hFFFF_FFFF, drops_since_last_marker[7:0]}`, saturating at 8'hFF, and `out_is_event = 0`.
  - On that load, `marker_pending` and the local drop counter clear.
  - A drop on the same edge as the marker load sets `marker_pending` again with count 1.
- `PACKET_SCHEDULER_OVERFLOW_MARKER_EN` undefined:
  - No marker state or logic exists, and boundaries never emit markers.
  - `drop_count` still operates.

## Test plan
- Reset, then 3 boundary pulses with no input: `out_data` stays 40'h0 and `out_is_event` stays 0.
- Push 40'h0000_0010_A5, then pulse a boundary: `out_data = 40'h0000_0010_A5`, `out_is_event = 1`, `fifo_level` goes 1→0. Next pulse: `IDLE_WORD`.
- Push 16 events with `ADDR_W=4`, then offer 2 more: `in_ready = 0` after the 16th, `drop_count = 2`, and 16 boundaries return the events in order.
- Same-cycle push and boundary at `fifo_level = 5`: level stays 5 and the head loads correctly.
- Macro on: overflow by 3, then boundary: `out_data = 40'hFFFF_FFFF_03`. Next boundary delivers the oldest FIFO entry.
- Assert `rst` for one cycle with 7 entries loaded and `EVENT` active: all outputs return to reset values and the next boundary gives `IDLE_WORD`.
